// File: rtl/jpeg_header_stream_if.sv
// Output word stream of the JFIF header generator: packed big-endian words
// with byte-lane enables on a valid/ready handshake.
interface jpeg_header_stream_if;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_be, output out_valid, input out_ready);
    modport slave  (input out_data, input out_be, input out_valid, output out_ready);
endinterface

// File: rtl/jpeg_header_stream.sv
// JFIF header generator: SOI/APP0, quality-scaled DQT tables, SOF0, DHT from
// ROM and SOS, emitted as one byte stream packed into 32-bit words.
//
// Pipeline: the sequencer picks one byte per cycle (constant or ROM read),
// stage 1 holds that byte until the packer takes it, and the packer gathers
// four bytes into the output word register.
//
// state      | meaning
// -----------+----------------------------------------------
// S_IDLE     | waiting for start
// S_SOI_APP0 | SOI marker and fixed APP0 JFIF segment
// S_DQT      | one DQT segment per table, tbl_q selects table
// S_SOF      | SOF0; holds at the height bytes until dims valid
// S_DHT      | FFC4 then the whole DHT ROM
// S_SOS      | SOS segment; its last byte is flagged as final
// S_FLUSH    | waiting for the final (possibly partial) word
module jpeg_header_stream #(
    parameter int NUM_QT    = 2,
    parameter int NUM_COMP  = 3,
    parameter int DHT_BYTES = 418,
    parameter int QA_W      = 7,
    parameter int DA_W      = 9
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [7:0]           scale_pct_i,
    input  logic                 dimensions_valid_i,
    input  logic [15:0]          line_width_i,
    input  logic [15:0]          pic_height_i,
    output logic                 qt_rd_o,
    output logic [QA_W-1:0]      qt_addr_o,
    input  logic [7:0]           qt_data_i,
    output logic                 dht_rd_o,
    output logic [DA_W-1:0]      dht_addr_o,
    input  logic [7:0]           dht_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    jpeg_header_stream_if.master out_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOI_APP0, S_DQT, S_SOF, S_DHT, S_SOS, S_FLUSH
    } state_t;

    typedef enum logic [1:0] {SRC_CONST, SRC_QT, SRC_DHT} src_t;

    localparam logic [7:0]  SOF_LEN  = 8'(8 + 3 * NUM_COMP);
    localparam logic [7:0]  SOS_LEN  = 8'(6 + 2 * NUM_COMP);
    localparam logic [7:0]  NC8      = 8'(NUM_COMP);
    localparam logic [7:0]  QT_LAST  = 8'(NUM_QT - 1);
    localparam logic [15:0] SOF_END  = 16'(9 + 3 * NUM_COMP);
    localparam logic [15:0] SOS_TAIL = 16'(5 + 2 * NUM_COMP);
    localparam logic [15:0] SOS_END  = 16'(7 + 2 * NUM_COMP);
    localparam logic [15:0] DHT_END  = 16'(DHT_BYTES + 1);

    state_t          state_q, state_d;
    logic [15:0]     idx_q, idx_d;
    logic [7:0]      tbl_q, tbl_d;
    logic [7:0]      scale_q, scale_d;
    logic [QA_W-1:0] qt_addr_q, qt_addr_d;
    logic [DA_W-1:0] dht_addr_q, dht_addr_d;

    logic            s1_valid_q, s1_valid_d;
    src_t            s1_src_q, s1_src_d;
    logic [7:0]      s1_byte_q, s1_byte_d;
    logic            s1_last_q, s1_last_d;

    logic [23:0]     acc_q, acc_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [3:0]      out_be_q, out_be_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic [7:0]      cur_byte;
    src_t            cur_src;
    logic            seg_last;
    logic            in_seg, dim_hold, issue, adv, take, pk_ready, out_free, accept;
    logic [16:0]     qt_prod, qt_quo;
    logic [7:0]      qt_scaled, s1_out;

    // Quantiser scaling with rounding, clamped to 1..255.
    assign qt_prod   = 17'(qt_data_i) * 17'(scale_q) + 17'd50;
    assign qt_quo    = qt_prod / 17'd100;
    assign qt_scaled = (qt_quo > 17'd255) ? 8'hFF :
                       (qt_quo == 17'd0)  ? 8'h01 : qt_quo[7:0];

    // A fresh ROM byte is only on the data bus the cycle after its read.
    assign s1_out = (s1_src_q == SRC_QT)  ? qt_scaled  :
                    (s1_src_q == SRC_DHT) ? dht_data_i : s1_byte_q;

    assign out_free = !out_valid_q || out_if.out_ready;
    assign pk_ready = out_free || ((cnt_q != 2'd3) && !s1_last_q);
    assign take     = s1_valid_q && pk_ready;
    assign adv      = !s1_valid_q || take;
    assign in_seg   = (state_q == S_SOI_APP0) || (state_q == S_DQT) || (state_q == S_SOF) ||
                      (state_q == S_DHT) || (state_q == S_SOS);
    assign dim_hold = (state_q == S_SOF) && (idx_q == 16'd5) && !dimensions_valid_i;
    assign issue    = in_seg && adv && !dim_hold;
    assign done_o   = out_valid_q && out_if.out_ready && out_last_q;
    assign accept   = start_i && ((state_q == S_IDLE) || ((state_q == S_FLUSH) && done_o));

    assign qt_rd_o    = issue && (cur_src == SRC_QT);
    assign qt_addr_o  = qt_addr_q;
    assign dht_rd_o   = issue && (cur_src == SRC_DHT);
    assign dht_addr_o = dht_addr_q;
    assign busy_o     = (state_q != S_IDLE);

    assign out_if.out_data  = out_data_q;
    assign out_if.out_be    = out_be_q;
    assign out_if.out_valid = out_valid_q;

    // Decode the byte the sequencer would emit at the current position.
    always_comb begin
        cur_byte = 8'h00;
        cur_src  = SRC_CONST;
        seg_last = 1'b0;
        case (state_q)
            S_SOI_APP0: begin
                case (idx_q)
                    16'd0:  cur_byte = 8'hFF;
                    16'd1:  cur_byte = 8'hD8;
                    16'd2:  cur_byte = 8'hFF;
                    16'd3:  cur_byte = 8'hE0;
                    16'd5:  cur_byte = 8'h10;
                    16'd6:  cur_byte = 8'h4A;
                    16'd7:  cur_byte = 8'h46;
                    16'd8:  cur_byte = 8'h49;
                    16'd9:  cur_byte = 8'h46;
                    16'd11: cur_byte = 8'h01;
                    16'd12: cur_byte = 8'h01;
                    16'd15: cur_byte = 8'h01;
                    16'd17: cur_byte = 8'h01;
                    default: cur_byte = 8'h00;
                endcase
                seg_last = (idx_q == 16'd19);
            end
            S_DQT: begin
                case (idx_q)
                    16'd0:   cur_byte = 8'hFF;
                    16'd1:   cur_byte = 8'hDB;
                    16'd2:   cur_byte = 8'h00;
                    16'd3:   cur_byte = 8'h43;
                    16'd4:   cur_byte = tbl_q;
                    default: cur_src  = SRC_QT;
                endcase
                seg_last = (idx_q == 16'd68);
            end
            S_SOF: begin
                case (idx_q)
                    16'd0:  cur_byte = 8'hFF;
                    16'd1:  cur_byte = 8'hC0;
                    16'd3:  cur_byte = SOF_LEN;
                    16'd4:  cur_byte = 8'h08;
                    16'd5:  cur_byte = pic_height_i[15:8];
                    16'd6:  cur_byte = pic_height_i[7:0];
                    16'd7:  cur_byte = line_width_i[15:8];
                    16'd8:  cur_byte = line_width_i[7:0];
                    16'd9:  cur_byte = NC8;
                    16'd10: cur_byte = 8'h01;
                    16'd11: cur_byte = 8'h11;
                    16'd13: cur_byte = 8'h02;
                    16'd14: cur_byte = 8'h11;
                    16'd15: cur_byte = QT_LAST;
                    16'd16: cur_byte = 8'h03;
                    16'd17: cur_byte = 8'h11;
                    16'd18: cur_byte = QT_LAST;
                    default: cur_byte = 8'h00;
                endcase
                seg_last = (idx_q == SOF_END);
            end
            S_DHT: begin
                case (idx_q)
                    16'd0:   cur_byte = 8'hFF;
                    16'd1:   cur_byte = 8'hC4;
                    default: cur_src  = SRC_DHT;
                endcase
                seg_last = (idx_q == DHT_END);
            end
            S_SOS: begin
                case (idx_q)
                    16'd0:  cur_byte = 8'hFF;
                    16'd1:  cur_byte = 8'hDA;
                    16'd3:  cur_byte = SOS_LEN;
                    16'd4:  cur_byte = NC8;
                    16'd5:  cur_byte = 8'h01;
                    16'd7:  cur_byte = 8'h02;
                    16'd8:  cur_byte = 8'h11;
                    16'd9:  cur_byte = 8'h03;
                    16'd10: cur_byte = 8'h11;
                    default: cur_byte = 8'h00;
                endcase
                // Trailer 00 3F 00 overrides the component table when NUM_COMP is small.
                if (idx_q >= SOS_TAIL) begin
                    cur_byte = (idx_q == SOS_TAIL + 16'd1) ? 8'h3F : 8'h00;
                end
                seg_last = (idx_q == SOS_END);
            end
            default: begin
                cur_byte = 8'h00;
            end
        endcase
    end

    // Sequencer next state: segment order, ROM addressing and the stage-1 skid.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tbl_d      = tbl_q;
        scale_d    = scale_q;
        qt_addr_d  = qt_addr_q;
        dht_addr_d = dht_addr_q;
        s1_valid_d = s1_valid_q;
        s1_src_d   = s1_src_q;
        s1_byte_d  = s1_byte_q;
        s1_last_d  = s1_last_q;

        if (take) begin
            s1_valid_d = 1'b0;
        end else if (s1_valid_q && (s1_src_q != SRC_CONST)) begin
            // Packer stalled: capture the ROM byte before the bus moves on.
            s1_byte_d = s1_out;
            s1_src_d  = SRC_CONST;
        end

        if (issue) begin
            s1_valid_d = 1'b1;
            s1_src_d   = cur_src;
            s1_byte_d  = cur_byte;
            s1_last_d  = (state_q == S_SOS) && seg_last;
            idx_d      = seg_last ? 16'd0 : idx_q + 16'd1;
            if (cur_src == SRC_QT)  qt_addr_d  = qt_addr_q + QA_W'(1);
            if (cur_src == SRC_DHT) dht_addr_d = dht_addr_q + DA_W'(1);
            if (seg_last) begin
                case (state_q)
                    S_SOI_APP0: state_d = S_DQT;
                    S_DQT: begin
                        if (tbl_q == QT_LAST) state_d = S_SOF;
                        else                  tbl_d   = tbl_q + 8'd1;
                    end
                    S_SOF:   state_d = S_DHT;
                    S_DHT:   state_d = S_SOS;
                    S_SOS:   state_d = S_FLUSH;
                    default: state_d = state_q;
                endcase
            end
        end

        if ((state_q == S_FLUSH) && done_o) state_d = S_IDLE;

        if (accept) begin
            state_d    = S_SOI_APP0;
            idx_d      = 16'd0;
            tbl_d      = 8'd0;
            qt_addr_d  = '0;
            dht_addr_d = '0;
            scale_d    = scale_pct_i;
        end
    end

    // Packer: gather bytes MSB-first; the final byte closes a partial word.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_be_d    = out_be_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_if.out_ready) out_valid_d = 1'b0;

        if (take) begin
            if ((cnt_q == 2'd3) || s1_last_q) begin
                out_valid_d = 1'b1;
                out_last_d  = s1_last_q;
                cnt_d       = 2'd0;
                acc_d       = 24'd0;
                case (cnt_q)
                    2'd0: begin out_data_d = {s1_out, 24'd0};            out_be_d = 4'b1000; end
                    2'd1: begin out_data_d = {acc_q[7:0], s1_out, 16'd0}; out_be_d = 4'b1100; end
                    2'd2: begin out_data_d = {acc_q[15:0], s1_out, 8'd0}; out_be_d = 4'b1110; end
                    default: begin out_data_d = {acc_q, s1_out};         out_be_d = 4'b1111; end
                endcase
            end else begin
                acc_d = {acc_q[15:0], s1_out};
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    // State, pipeline and packer registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 16'd0;
            tbl_q       <= 8'd0;
            scale_q     <= 8'd0;
            qt_addr_q   <= '0;
            dht_addr_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_src_q    <= SRC_CONST;
            s1_byte_q   <= 8'd0;
            s1_last_q   <= 1'b0;
            acc_q       <= 24'd0;
            cnt_q       <= 2'd0;
            out_data_q  <= 32'd0;
            out_be_q    <= 4'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tbl_q       <= tbl_d;
            scale_q     <= scale_d;
            qt_addr_q   <= qt_addr_d;
            dht_addr_q  <= dht_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_src_q    <= s1_src_d;
            s1_byte_q   <= s1_byte_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_be_q    <= out_be_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_jpeg_header_stream.sv
// Scoreboard bench for jpeg_header_stream: expected words are queued when a
// header is started; monitors pop and compare on every accepted word.
module tb_jpeg_header_stream;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  be;
        bit          last;
    } wexp_t;

    logic        clk, rst;
    logic        start_a, start_b, dims;
    logic [7:0]  scale;
    logic [15:0] w, h;
    logic        qt_rd_a, dht_rd_a, busy_a, done_a;
    logic [6:0]  qt_addr_a;
    logic [8:0]  dht_addr_a;
    logic [7:0]  qt_data_a, dht_data_a;
    logic        qt_rd_b, dht_rd_b, busy_b, done_b;
    logic [6:0]  qt_addr_b;
    logic [8:0]  dht_addr_b;
    logic [7:0]  qt_data_b, dht_data_b;

    int total = 0, bad = 0;
    int qmode = 0;
    bit rnd_ready = 0;
    wexp_t exp_a[$], exp_b[$];
    int wcnt_a = 0, wcnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int widx_a = 0, widx_b = 0;
    bit pv_a = 0, pr_a = 0;
    logic [31:0] pd_a;
    logic [3:0]  pb_a;

    jpeg_header_stream_if if_a();
    jpeg_header_stream_if if_b();

    jpeg_header_stream dut_a (
        .clk_in(clk), .rst(rst), .start_i(start_a), .scale_pct_i(scale),
        .dimensions_valid_i(dims), .line_width_i(w), .pic_height_i(h),
        .qt_rd_o(qt_rd_a), .qt_addr_o(qt_addr_a), .qt_data_i(qt_data_a),
        .dht_rd_o(dht_rd_a), .dht_addr_o(dht_addr_a), .dht_data_i(dht_data_a),
        .busy_o(busy_a), .done_o(done_a), .out_if(if_a)
    );

    jpeg_header_stream #(.NUM_QT(1), .NUM_COMP(1)) dut_b (
        .clk_in(clk), .rst(rst), .start_i(start_b), .scale_pct_i(scale),
        .dimensions_valid_i(dims), .line_width_i(w), .pic_height_i(h),
        .qt_rd_o(qt_rd_b), .qt_addr_o(qt_addr_b), .qt_data_i(qt_data_b),
        .dht_rd_o(dht_rd_b), .dht_addr_o(dht_addr_b), .dht_data_i(dht_data_b),
        .busy_o(busy_b), .done_o(done_b), .out_if(if_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] qrom(int m, int a);
        return (m == 1) ? 8'(255 - a) : 8'(a);
    endfunction

    function automatic logic [7:0] drom(int a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    function automatic logic [7:0] sc(int q, int pct);
        int s;
        s = (q * pct + 50) / 100;
        if (s > 255) return 8'hFF;
        if (s == 0)  return 8'h01;
        return 8'(s);
    endfunction

    // ROM models, one-cycle read latency
    always @(posedge clk) begin
        if (qt_rd_a)  qt_data_a  <= qrom(qmode, int'(qt_addr_a));
        if (dht_rd_a) dht_data_a <= drom(int'(dht_addr_a));
        if (qt_rd_b)  qt_data_b  <= qrom(qmode, int'(qt_addr_b));
        if (dht_rd_b) dht_data_b <= drom(int'(dht_addr_b));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Build the expected header byte stream and queue it as packed words.
    task automatic build(input bit sel_b, input int nq, input int nc, input int pct, input int m,
                         output int nw);
        logic [7:0] bq[$];
        wexp_t e;
        int app0[20] = '{'hFF,'hD8,'hFF,'hE0,'h00,'h10,'h4A,'h46,'h49,'h46,
                         'h00,'h01,'h01,'h00,'h00,'h01,'h00,'h01,'h00,'h00};
        for (int i = 0; i < 20; i++) bq.push_back(8'(app0[i]));
        for (int t = 0; t < nq; t++) begin
            bq.push_back(8'hFF); bq.push_back(8'hDB); bq.push_back(8'h00); bq.push_back(8'h43);
            bq.push_back(8'(t));
            for (int j = 0; j < 64; j++) bq.push_back(sc(int'(qrom(m, t * 64 + j)), pct));
        end
        bq.push_back(8'hFF); bq.push_back(8'hC0); bq.push_back(8'h00); bq.push_back(8'(8 + 3 * nc));
        bq.push_back(8'h08); bq.push_back(h[15:8]); bq.push_back(h[7:0]);
        bq.push_back(w[15:8]); bq.push_back(w[7:0]); bq.push_back(8'(nc));
        for (int c = 1; c <= nc; c++) begin
            bq.push_back(8'(c)); bq.push_back(8'h11); bq.push_back((c == 1) ? 8'h00 : 8'(nq - 1));
        end
        bq.push_back(8'hFF); bq.push_back(8'hC4);
        for (int i = 0; i < 418; i++) bq.push_back(drom(i));
        bq.push_back(8'hFF); bq.push_back(8'hDA); bq.push_back(8'h00); bq.push_back(8'(6 + 2 * nc));
        bq.push_back(8'(nc));
        for (int c = 1; c <= nc; c++) begin
            bq.push_back(8'(c)); bq.push_back((c == 1) ? 8'h00 : 8'h11);
        end
        bq.push_back(8'h00); bq.push_back(8'h3F); bq.push_back(8'h00);
        nw = 0;
        for (int i = 0; i < bq.size(); i += 4) begin
            e.d = 32'd0; e.be = 4'd0;
            for (int k = 0; k < 4; k++) begin
                if (i + k < bq.size()) begin
                    e.d[31 - 8 * k -: 8] = bq[i + k];
                    e.be[3 - k] = 1'b1;
                end
            end
            e.last = (i + 4 >= bq.size());
            if (sel_b) exp_b.push_back(e); else exp_a.push_back(e);
            nw++;
        end
    endtask

    // out_ready driver for DUT A, changed just after each rising edge
    initial begin
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if_a.out_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Monitor A: stall stability, scoreboard pop, done alignment
    always @(negedge clk) begin
        wexp_t e;
        if (rst) begin
            widx_a = 0;
            pv_a = 0;
        end else begin
            if (pv_a && !pr_a) begin
                total++;
                if (!(if_a.out_valid && if_a.out_data == pd_a && if_a.out_be == pb_a)) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h/%b want v=1 %h/%b",
                             if_a.out_valid, if_a.out_data, if_a.out_be, pd_a, pb_a);
                end
            end
            if (if_a.out_valid && if_a.out_ready) begin
                wcnt_a++;
                if (exp_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_extra_word: got %h want none", if_a.out_data);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_word", if_a.out_data, e.d);
                    chk("a_be", {28'd0, if_a.out_be}, {28'd0, e.be});
                    chk("a_done_align", {31'd0, done_a}, {31'd0, e.last});
                    if (widx_a == 0) chk("a_word0", if_a.out_data, 32'hFFD8FFE0);
                    widx_a = e.last ? 0 : widx_a + 1;
                end
            end else if (done_a) begin
                total++; bad++;
                $display("FAIL a_done_stray: got done=1 want 0");
            end
            if (done_a) done_cnt_a++;
            pv_a = if_a.out_valid; pr_a = if_a.out_ready;
            pd_a = if_a.out_data;  pb_a = if_a.out_be;
        end
    end

    // Monitor B (single-table, single-component instance)
    always @(negedge clk) begin
        wexp_t e;
        if (!rst && if_b.out_valid && if_b.out_ready) begin
            wcnt_b++;
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_extra_word: got %h want none", if_b.out_data);
            end else begin
                e = exp_b.pop_front();
                chk("b_word", if_b.out_data, e.d);
                chk("b_be", {28'd0, if_b.out_be}, {28'd0, e.be});
                chk("b_done_align", {31'd0, done_b}, {31'd0, e.last});
                if (widx_b == 0) chk("b_word0", if_b.out_data, 32'hFFD8FFE0);
                widx_b = e.last ? 0 : widx_b + 1;
            end
        end
        if (!rst && done_b) done_cnt_b++;
    end

    task automatic pulse_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done_a) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL a_done_timeout: got no done want done within %0d", budget);
        end
    endtask

    initial begin
        int nw, rdcnt;
        bit seen;
        rst = 1; start_a = 0; start_b = 0; dims = 1; scale = 8'd100;
        w = 16'd1920; h = 16'd1080;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_done",  {31'd0, done_a}, 32'd0);
        chk("rst_qt_rd", {31'd0, qt_rd_a}, 32'd0);
        chk("rst_dht_rd", {31'd0, dht_rd_a}, 32'd0);
        chk("rst_data",  if_a.out_data, 32'd0);
        @(negedge clk); rst = 0;

        // Run 1: defaults, scale 100, no stalls; instance B alongside
        qmode = 0; scale = 8'd100;
        build(0, 2, 3, 100, 0, nw);
        build(1, 1, 1, 100, 0, nw);
        @(negedge clk); start_a = 1; start_b = 1;
        @(negedge clk); start_a = 0; start_b = 0;
        chk("busy_after_start", {31'd0, busy_a}, 32'd1);
        wait_done_a(3000);
        @(posedge clk); #1;
        chk("r1_words", 32'(wcnt_a), 32'd153);
        chk("r1_done_cnt", 32'(done_cnt_a), 32'd1);
        chk("r1_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("b_words", 32'(wcnt_b), 32'd133);
        chk("b_done_cnt", 32'(done_cnt_b), 32'd1);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);

        // Run 2: scale 50 with random back-pressure; run 3 starts on its done cycle
        rnd_ready = 1; scale = 8'd50;
        build(0, 2, 3, 50, 0, nw);
        pulse_a();
        wait_done_a(8000);
        rnd_ready = 0; scale = 8'd200; qmode = 1;
        build(0, 2, 3, 200, 1, nw);
        start_a = 1;
        @(posedge clk); #1; start_a = 0;
        chk("chain_accept_busy", {31'd0, busy_a}, 32'd1);
        chk("chain_queue", 32'(exp_a.size()), 32'(nw));
        wait_done_a(3000);
        @(posedge clk); #1;
        chk("r3_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("r3_done_cnt", 32'(done_cnt_a), 32'd3);

        // Run 4: scale 25, dimensions invalid -> hold at height bytes
        qmode = 0; scale = 8'd25; dims = 0;
        build(0, 2, 3, 25, 0, nw);
        pulse_a();
        rdcnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c >= 180 && (qt_rd_a || dht_rd_a)) rdcnt++;
        end
        chk("dims_hold_no_rd", 32'(rdcnt), 32'd0);
        chk("dims_hold_busy", {31'd0, busy_a}, 32'd1);
        chk("dims_hold_queue", 32'(exp_a.size() > 100), 32'd1);
        dims = 1;
        wait_done_a(3000);
        @(posedge clk); #1;
        chk("r4_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("r4_done_cnt", 32'(done_cnt_a), 32'd4);

        // Run 5: reset in the middle of DHT, then a clean header
        scale = 8'd100;
        build(0, 2, 3, 100, 0, nw);
        pulse_a();
        seen = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (dht_rd_a) begin seen = 1; break; end
        end
        chk("r5_reached_dht", {31'd0, seen}, 32'd1);
        repeat (30) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_valid", {31'd0, if_a.out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_dht_rd", {31'd0, dht_rd_a}, 32'd0);
        exp_a.delete();
        @(negedge clk); rst = 0;
        build(0, 2, 3, 100, 0, nw);
        pulse_a();
        wait_done_a(3000);
        @(posedge clk); #1;
        chk("r6_queue_empty", 32'(exp_a.size()), 32'd0);
        chk("r6_done_cnt", 32'(done_cnt_a), 32'd5);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
